// File: rtl/johnson_ring_seq.sv
// N-stage Johnson (twisted-ring) sequencer with one-hot decode, binary index,
// up/down stepping, index load, wrap pulse and illegal-state self-correction.
module johnson_ring_seq #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(2*N)
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            en,
    input  logic            dir,
    input  logic            load,
    input  logic [IW-1:0]   ld_idx,
    output logic [N-1:0]    q,
    output logic [2*N-1:0]  s,
    output logic [IW-1:0]   idx,
    output logic            wrap,
    output logic            err
);

    localparam int unsigned NS = 2 * N;

    logic [N-1:0]   q_q,    q_d;
    logic           wrap_q, wrap_d;
    logic           err_q,  err_d;
    logic           legal_c;
    logic [IW-1:0]  idx_c;
    logic [NS-1:0]  s_c;

    // Register pattern of state k; any k >= 2N yields all zeros.
    function automatic logic [N-1:0] state_pattern(input int unsigned k);
        logic [N-1:0] p;
        p = '0;
        for (int unsigned b = 0; b < N; b++) begin
            if (k <= N) p[b] = (b < k);
            else        p[b] = (b >= k - N);
        end
        return p;
    endfunction

    // Binary index and legality: match the register against every legal pattern.
    always_comb begin
        legal_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (q_q == state_pattern(k)) begin
                legal_c = 1'b1;
                idx_c   = IW'(k);
            end
        end
    end

    // Two-bit adjacent-stage decode; not one-hot when the register is illegal.
    always_comb begin
        s_c    = '0;
        s_c[0] = ~q_q[0] & ~q_q[N-1];
        s_c[N] =  q_q[0] &  q_q[N-1];
        for (int unsigned k = 1; k < N; k++) begin
            s_c[k]     =  q_q[k-1] & ~q_q[k];
            s_c[N + k] = ~q_q[k-1] &  q_q[k];
        end
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (!legal_c) begin
            q_d   = '0;
            err_d = 1'b1;
        end else if (load) begin
            q_d = (32'(ld_idx) < NS) ? state_pattern(32'(ld_idx)) : '0;
        end else if (en) begin
            if (dir) begin
                q_d    = {q_q[N-2:0], ~q_q[N-1]};
                wrap_d = (idx_c == IW'(NS - 1));
            end else begin
                q_d    = {~q_q[0], q_q[N-1:1]};
                wrap_d = (idx_c == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign s    = s_c;
    assign idx  = idx_c;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_johnson_ring_seq.sv
// Directed bench for johnson_ring_seq with N=4 main instance plus N=2, N=5 and N=7.
module tb_johnson_ring_seq;

    logic clk;
    logic clear, en, dir, load;
    logic [2:0] ld4;
    logic [1:0] ld2;
    logic [3:0] ld5, ld7;

    logic [3:0]  q4;  logic [7:0]  s4;  logic [2:0] idx4; logic wrap4, err4;
    logic [1:0]  q2;  logic [3:0]  s2;  logic [1:0] idx2; logic wrap2, err2;
    logic [4:0]  q5;  logic [9:0]  s5;  logic [3:0] idx5; logic wrap5, err5;
    logic [6:0]  q7;  logic [13:0] s7;  logic [3:0] idx7; logic wrap7, err7;

    int checks;
    int failures;

    logic [3:0] pat4 [0:7]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [1:0] pat2 [0:3]  = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [6:0] pat7 [0:13] = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F,
                                7'h7F, 7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h40};

    johnson_ring_seq #(.N(4)) dut4 (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .ld_idx(ld4),
        .q(q4), .s(s4), .idx(idx4), .wrap(wrap4), .err(err4));
    johnson_ring_seq #(.N(2)) dut2 (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .ld_idx(ld2),
        .q(q2), .s(s2), .idx(idx2), .wrap(wrap2), .err(err2));
    johnson_ring_seq #(.N(5)) dut5 (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .ld_idx(ld5),
        .q(q5), .s(s5), .idx(idx5), .wrap(wrap5), .err(err5));
    johnson_ring_seq #(.N(7)) dut7 (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .ld_idx(ld7),
        .q(q7), .s(s7), .idx(idx7), .wrap(wrap7), .err(err7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        en = 1'b0; load = 1'b0; dir = 1'b1;
        clear = 1'b0;
        tick();
        tick();
        clear = 1'b1;
    endtask

    task automatic test_reset;
        clear = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b1;
        ld4 = '0; ld2 = '0; ld5 = '0; ld7 = '0;
        #1 clear = 1'b0;
        #1;
        checks++; if (q4 !== 4'b0000) begin failures++; $display("FAIL reset_q got %b exp 0000", q4); end
        checks++; if (s4 !== 8'h01) begin failures++; $display("FAIL reset_s got %h exp 01", s4); end
        checks++; if (idx4 !== 3'd0) begin failures++; $display("FAIL reset_idx got %0d exp 0", idx4); end
        checks++; if (wrap4 !== 1'b0 || err4 !== 1'b0) begin failures++; $display("FAIL reset_flags got wrap=%b err=%b exp 0 0", wrap4, err4); end
        // Mid-count reset while wrap is high, between clock edges.
        do_reset();
        en = 1'b1; dir = 1'b0;
        tick();
        checks++; if (q4 !== 4'b1000 || wrap4 !== 1'b1) begin failures++; $display("FAIL pre_reset got q=%b wrap=%b exp 1000 1", q4, wrap4); end
        #3 clear = 1'b0;
        #1;
        checks++; if (q4 !== 4'b0000 || s4 !== 8'h01 || idx4 !== 3'd0) begin failures++; $display("FAIL midreset_state got q=%b s=%h idx=%0d exp 0000 01 0", q4, s4, idx4); end
        checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL midreset_wrap got %b exp 0", wrap4); end
        tick();
        clear = 1'b1; dir = 1'b1;
        tick();
        checks++; if (q4 !== 4'b0001 || idx4 !== 3'd1) begin failures++; $display("FAIL restart_up got q=%b idx=%0d exp 0001 1", q4, idx4); end
    endtask

    task automatic test_up_count;
        logic [7:0] exp_s;
        int k;
        do_reset();
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            k = (i + 1) % 8;
            exp_s = 8'(1) << k;
            checks++; if (q4 !== pat4[k]) begin failures++; $display("FAIL up_q step %0d got %b exp %b", i, q4, pat4[k]); end
            checks++; if (idx4 !== 3'(k)) begin failures++; $display("FAIL up_idx step %0d got %0d exp %0d", i, idx4, k); end
            checks++; if (s4 !== exp_s) begin failures++; $display("FAIL up_s step %0d got %b exp %b", i, s4, exp_s); end
            checks++; if (wrap4 !== (k == 0)) begin failures++; $display("FAIL up_wrap step %0d got %b exp %b", i, wrap4, (k == 0)); end
            checks++; if (err4 !== 1'b0) begin failures++; $display("FAIL up_err step %0d got %b exp 0", i, err4); end
        end
    endtask

    task automatic test_down_count;
        int k;
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            k = 7 - i;
            checks++; if (q4 !== pat4[k]) begin failures++; $display("FAIL down_q step %0d got %b exp %b", i, q4, pat4[k]); end
            checks++; if (idx4 !== 3'(k)) begin failures++; $display("FAIL down_idx step %0d got %0d exp %0d", i, idx4, k); end
            checks++; if (wrap4 !== (i == 0)) begin failures++; $display("FAIL down_wrap step %0d got %b exp %b", i, wrap4, (i == 0)); end
        end
        dir = 1'b1;
        tick();
        checks++; if (idx4 !== 3'd6 || q4 !== 4'b1100) begin failures++; $display("FAIL reverse got idx=%0d q=%b exp 6 1100", idx4, q4); end
        checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL reverse_wrap got %b exp 0", wrap4); end
    endtask

    task automatic test_load;
        load = 1'b1; en = 1'b1; dir = 1'b1;
        ld4 = 3'd5; ld5 = 4'd9;
        tick();
        checks++; if (q4 !== 4'b1110 || idx4 !== 3'd5) begin failures++; $display("FAIL load5 got q=%b idx=%0d exp 1110 5", q4, idx4); end
        checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL load5_wrap got %b exp 0", wrap4); end
        checks++; if (q5 !== 5'b10000 || idx5 !== 4'd9 || s5 !== 10'b10_0000_0000) begin failures++; $display("FAIL n5_load9 got q=%b idx=%0d s=%b exp 10000 9 1000000000", q5, idx5, s5); end
        ld4 = 3'd7; ld5 = 4'd10;
        tick();
        checks++; if (q4 !== 4'b1000 || idx4 !== 3'd7) begin failures++; $display("FAIL load7 got q=%b idx=%0d exp 1000 7", q4, idx4); end
        checks++; if (q5 !== 5'b00000 || idx5 !== 4'd0 || wrap5 !== 1'b0 || err5 !== 1'b0) begin failures++; $display("FAIL n5_load10 got q=%b idx=%0d w=%b e=%b exp 00000 0 0 0", q5, idx5, wrap5, err5); end
        // Load wins over an enabled step that would otherwise wrap.
        ld4 = 3'd0;
        tick();
        checks++; if (q4 !== 4'b0000 || wrap4 !== 1'b0) begin failures++; $display("FAIL load_over_wrap got q=%b wrap=%b exp 0000 0", q4, wrap4); end
        load = 1'b0;
        tick();
        checks++; if (q4 !== 4'b0001 || wrap4 !== 1'b0) begin failures++; $display("FAIL post_load_step got q=%b wrap=%b exp 0001 0", q4, wrap4); end
    endtask

    task automatic test_illegal;
        force dut4.q_q = 4'b0101;
        #1;
        checks++; if (idx4 !== 3'd0) begin failures++; $display("FAIL illegal_idx got %0d exp 0", idx4); end
        checks++; if (s4 !== 8'b0100_1010) begin failures++; $display("FAIL illegal_s got %b exp 01001010", s4); end
        release dut4.q_q;
        load = 1'b1; ld4 = 3'd3; en = 1'b1; dir = 1'b1;
        tick();
        checks++; if (q4 !== 4'b0000) begin failures++; $display("FAIL illegal_fix got %b exp 0000", q4); end
        checks++; if (err4 !== 1'b1 || wrap4 !== 1'b0) begin failures++; $display("FAIL illegal_err got err=%b wrap=%b exp 1 0", err4, wrap4); end
        load = 1'b0; en = 1'b0;
        tick();
        checks++; if (err4 !== 1'b0 || q4 !== 4'b0000) begin failures++; $display("FAIL illegal_after got err=%b q=%b exp 0 0000", err4, q4); end
    endtask

    task automatic test_hold;
        load = 1'b1; ld4 = 3'd2; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b0; dir = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (q4 !== 4'b0011 || idx4 !== 3'd2 || wrap4 !== 1'b0) begin failures++; $display("FAIL hold step %0d got q=%b idx=%0d wrap=%b exp 0011 2 0", i, q4, idx4, wrap4); end
        end
    endtask

    task automatic test_params;
        int k2;
        int k7;
        logic [3:0]  exp_s2;
        logic [13:0] exp_s7;
        do_reset();
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            k2 = (i + 1) % 4;
            k7 = (i + 1) % 14;
            exp_s2 = 4'(1) << k2;
            exp_s7 = 14'(1) << k7;
            checks++; if (q2 !== pat2[k2] || idx2 !== 2'(k2) || s2 !== exp_s2) begin failures++; $display("FAIL n2_up step %0d got q=%b idx=%0d s=%b exp %b %0d %b", i, q2, idx2, s2, pat2[k2], k2, exp_s2); end
            checks++; if (wrap2 !== (k2 == 0)) begin failures++; $display("FAIL n2_wrap step %0d got %b exp %b", i, wrap2, (k2 == 0)); end
            checks++; if (q7 !== pat7[k7] || idx7 !== 4'(k7) || s7 !== exp_s7) begin failures++; $display("FAIL n7_up step %0d got q=%b idx=%0d s=%b exp %b %0d %b", i, q7, idx7, s7, pat7[k7], k7, exp_s7); end
            checks++; if (wrap7 !== (k7 == 0)) begin failures++; $display("FAIL n7_wrap step %0d got %b exp %b", i, wrap7, (k7 == 0)); end
        end
        load = 1'b1; ld2 = 2'd3; ld7 = 4'd10;
        tick();
        checks++; if (q2 !== 2'b10 || idx2 !== 2'd3) begin failures++; $display("FAIL n2_load3 got q=%b idx=%0d exp 10 3", q2, idx2); end
        checks++; if (q7 !== 7'h78 || idx7 !== 4'd10) begin failures++; $display("FAIL n7_load10 got q=%h idx=%0d exp 78 10", q7, idx7); end
        ld2 = 2'd0; ld7 = 4'd14;
        tick();
        checks++; if (q2 !== 2'b00 || q7 !== 7'h00 || idx7 !== 4'd0) begin failures++; $display("FAIL param_load_zero got q2=%b q7=%h idx7=%0d exp 00 00 0", q2, q7, idx7); end
        load = 1'b0; dir = 1'b0;
        tick();
        checks++; if (q2 !== 2'b10 || idx2 !== 2'd3 || wrap2 !== 1'b1 || err2 !== 1'b0) begin failures++; $display("FAIL n2_down got q=%b idx=%0d w=%b e=%b exp 10 3 1 0", q2, idx2, wrap2, err2); end
        checks++; if (q7 !== 7'h40 || idx7 !== 4'd13 || wrap7 !== 1'b1 || err7 !== 1'b0) begin failures++; $display("FAIL n7_down got q=%h idx=%0d w=%b e=%b exp 40 13 1 0", q7, idx7, wrap7, err7); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_illegal();
        test_hold();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
